// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives the imem read address and pairs each returned word with its PC.
// Latency: instruction valid one edge after its address is presented; a redirect costs one bubble.
// Backpressure: stall holds PC state and re-presents the in-flight address; redirect overrides stall.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   stall                           decode cannot accept this cycle
//   redirect_valid, redirect_target branch/jump redirect (target should be word aligned)
//   imem_addr, imem_instr           instruction memory address (comb) and returned word (1-cycle)
//   if_valid, if_instr, if_pc,      instruction presented to decode
//   if_pc_plus4
//   misalign_err                    one-cycle pulse for a misaligned redirect target
//   fetch_count                     instructions accepted by decode (wrapping)
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_target,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_instr,
   output logic             if_valid,
   output logic [31:0]      if_instr,
   output logic [31:0]      if_pc,
   output logic [31:0]      if_pc_plus4,
   output logic             misalign_err,
   output logic [CNT_W-1:0] fetch_count
);

   logic [31:0] pc_reg;     // next address to fetch
   logic [31:0] req_pc;     // address whose word is currently returning
   logic        req_valid;  // returning word is a real (right-path) instruction
   logic        accept;

   // The memory latches on every edge with no enable, so during a stall the
   // in-flight address is presented again to keep imem_instr steady.
   assign imem_addr   = (stall && !redirect_valid) ? req_pc : pc_reg;

   assign if_instr    = imem_instr;
   assign if_pc       = req_pc;
   assign if_valid    = req_valid;
   assign if_pc_plus4 = req_pc + 32'd4;

   assign accept      = req_valid && !stall && !redirect_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg       <= RESET_PC;
         req_pc       <= RESET_PC;
         req_valid    <= 1'b0;
         misalign_err <= 1'b0;
         fetch_count  <= '0;
      end else begin
         misalign_err <= 1'b0;
         if (redirect_valid) begin
            // Word fetched this edge is from the old path; drop it.
            pc_reg       <= redirect_target & ~32'h3;
            req_pc       <= pc_reg;
            req_valid    <= 1'b0;
            misalign_err <= |redirect_target[1:0];
         end else if (!stall) begin
            req_pc    <= pc_reg;
            pc_reg    <= pc_reg + 32'd4;
            req_valid <= 1'b1;
         end
         if (accept) begin
            fetch_count <= fetch_count + CNT_W'(1);
         end
      end
   end

endmodule
